// File: rtl/ascon_gate_pkg.sv
// Shared types and constants for the ASCON release gate: FSM states,
// the core's fault-substitution constant and the timeout counter sizing helper.
package ascon_gate_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ENC,
        WAIT_DEC,
        CHECK,
        RELEASE,
        FAULT,
        LOCKED
    } gate_state_e;

    localparam logic [127:0] FAULT_CONST_DEFAULT = 128'h8C784;

    // Bits needed to count from 0 up to timeout-1.
    function automatic int unsigned tmr_width(input int unsigned timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/ascon_release_gate_if.sv
// Consumer-side valid/ready handshake carrying the released ciphertext and tag.
interface ascon_release_gate_if #(
    parameter int unsigned Y = 40
) ();
    logic         out_valid;
    logic         out_ready;
    logic [Y-1:0] out_cipher_text;
    logic [127:0] out_tag;

    modport master (output out_valid, output out_cipher_text, output out_tag, input out_ready);
    modport slave  (input out_valid, input out_cipher_text, input out_tag, output out_ready);
endinterface

// File: rtl/ascon_timeout_ctr.sv
// Clearable up-counter with a terminal-count flag at TIMEOUT-1; holds at terminal count.
module ascon_timeout_ctr
    import ascon_gate_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TW      = tmr_width(TIMEOUT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);
    logic [TW-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (!tc)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ascon_release_gate.sv
// Release gate behind the fault-countermeasure ASCON core: checks round-trip tag
// and fault constants before releasing results. Optional macro: ASCON_PT_CHECK_EN.
module ascon_release_gate
    import ascon_gate_pkg::*;
#(
    parameter int unsigned  Y           = 40,
    parameter logic [127:0] FAULT_CONST = FAULT_CONST_DEFAULT,
    parameter int unsigned  TIMEOUT     = 1024,
    parameter int unsigned  LOCK_LIMIT  = 3,
    parameter int unsigned  CW          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [Y-1:0]          plain_text,
    input  logic [Y-1:0]          cipher_text,
    input  logic [127:0]          tag,
    input  logic                  encryption_ready,
    input  logic [Y-1:0]          dec_plain_text,
    input  logic [127:0]          dec_tag,
    input  logic                  decryption_ready,
    input  logic                  lock_clear,
    ascon_release_gate_if.master  rel,
    output logic                  fault,
    output logic [CW-1:0]         fault_count,
    output logic                  locked,
    output logic                  busy
);
    localparam int unsigned LW = $clog2(LOCK_LIMIT + 1);

    gate_state_e   state_q, state_d;
    logic          enc_rdy_q, dec_rdy_q;
    logic [Y-1:0]  ct_q, ct_d;
    logic [127:0]  tag_q, tag_d, dtag_q, dtag_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc;
    logic          enc_rise, dec_rise, tmr_clr, tmr_tc, check_ok;

`ifdef ASCON_PT_CHECK_EN
    logic [Y-1:0]  pt_q, pt_d, dpt_q, dpt_d;
`else
    logic          unused_pt;
    assign unused_pt = ^{plain_text, dec_plain_text};
`endif

    assign enc_rise = encryption_ready & ~enc_rdy_q;
    assign dec_rise = decryption_ready & ~dec_rdy_q;
    assign lcnt_inc = lcnt_q + 1'b1;

    ascon_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .tc  (tmr_tc)
    );

    always_comb begin
        check_ok = (tag_q == dtag_q) && (tag_q != FAULT_CONST) &&
                   (ct_q != FAULT_CONST[Y-1:0]) && (dtag_q != FAULT_CONST);
`ifdef ASCON_PT_CHECK_EN
        check_ok = check_ok && (dpt_q == pt_q);
`endif
    end

    always_comb begin
        // NOTE: every signal gets its default before the case so no latch is inferred.
        state_d = state_q;
        ct_d    = ct_q;
        tag_d   = tag_q;
        dtag_d  = dtag_q;
        fcnt_d  = fcnt_q;
        lcnt_d  = lcnt_q;
        tmr_clr = 1'b1;
`ifdef ASCON_PT_CHECK_EN
        pt_d    = pt_q;
        dpt_d   = dpt_q;
`endif
        unique case (state_q)
            IDLE: if (start) begin
`ifdef ASCON_PT_CHECK_EN
                pt_d = plain_text;
`endif
                state_d = WAIT_ENC;
            end
            WAIT_ENC: begin
                tmr_clr = 1'b0;
                if (enc_rise) begin
                    ct_d    = cipher_text;
                    tag_d   = tag;
                    tmr_clr = 1'b1;
                    state_d = WAIT_DEC;
                    // Both results arriving together skip straight to the check.
                    if (dec_rise) begin
                        dtag_d  = dec_tag;
`ifdef ASCON_PT_CHECK_EN
                        dpt_d   = dec_plain_text;
`endif
                        state_d = CHECK;
                    end
                end else if (tmr_tc) begin
                    state_d = FAULT;
                end
            end
            WAIT_DEC: begin
                tmr_clr = 1'b0;
                if (dec_rise) begin
                    dtag_d  = dec_tag;
`ifdef ASCON_PT_CHECK_EN
                    dpt_d   = dec_plain_text;
`endif
                    state_d = CHECK;
                end else if (tmr_tc) begin
                    state_d = FAULT;
                end
            end
            CHECK:   state_d = check_ok ? RELEASE : FAULT;
            RELEASE: if (rel.out_ready) state_d = IDLE;
            FAULT: begin
                fcnt_d  = (fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1;
                lcnt_d  = lcnt_inc;
                ct_d    = '0;
                tag_d   = '0;
                dtag_d  = '0;
`ifdef ASCON_PT_CHECK_EN
                pt_d    = '0;
                dpt_d   = '0;
`endif
                state_d = (lcnt_inc >= LW'(LOCK_LIMIT)) ? LOCKED : IDLE;
            end
            LOCKED: if (lock_clear) begin
                lcnt_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst) begin
            state_q   <= IDLE;
            enc_rdy_q <= 1'b0;
            dec_rdy_q <= 1'b0;
            ct_q      <= '0;
            tag_q     <= '0;
            dtag_q    <= '0;
            fcnt_q    <= '0;
            lcnt_q    <= '0;
`ifdef ASCON_PT_CHECK_EN
            pt_q      <= '0;
            dpt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            enc_rdy_q <= encryption_ready;
            dec_rdy_q <= decryption_ready;
            ct_q      <= ct_d;
            tag_q     <= tag_d;
            dtag_q    <= dtag_d;
            fcnt_q    <= fcnt_d;
            lcnt_q    <= lcnt_d;
`ifdef ASCON_PT_CHECK_EN
            pt_q      <= pt_d;
            dpt_q     <= dpt_d;
`endif
        end
    end

    // Data outputs are forced to zero outside RELEASE so unchecked data never leaks.
    assign rel.out_valid       = (state_q == RELEASE);
    assign rel.out_cipher_text = rel.out_valid ? ct_q  : '0;
    assign rel.out_tag         = rel.out_valid ? tag_q : '0;
    assign fault               = (state_q == FAULT);
    assign fault_count         = fcnt_q;
    assign locked              = (state_q == LOCKED);
    assign busy                = (state_q != IDLE) && (state_q != LOCKED);
endmodule

// File: tb/tb_ascon_release_gate.sv
// Directed, table-driven bench for ascon_release_gate plus hand sequences for
// lockout, timeouts, back-pressure and asynchronous reset.
module tb_ascon_release_gate;
    localparam int unsigned Y          = 40;
    localparam int unsigned TIMEOUT    = 1024;
    localparam int unsigned LOCK_LIMIT = 3;
    localparam int unsigned CW         = 8;

    typedef struct {
        string          name;
        int             enc_dly;
        int             dec_dly;
        logic [Y-1:0]   pt;
        logic [Y-1:0]   ct;
        logic [127:0]   tg;
        logic [127:0]   dtg;
        bit             pt_flip;
        bit             exp_rel;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [Y-1:0]   plain_text = '0;
    logic [Y-1:0]   cipher_text = '0;
    logic [127:0]   tag = '0;
    logic           encryption_ready = 1'b0;
    logic [Y-1:0]   dec_plain_text = '0;
    logic [127:0]   dec_tag = '0;
    logic           decryption_ready = 1'b0;
    logic           lock_clear = 1'b0;
    logic           fault;
    logic [CW-1:0]  fault_count;
    logic           locked;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_faults = 0;
    int exp_lock   = 0;

    ascon_release_gate_if #(.Y(Y)) rel_if ();

    ascon_release_gate #(
        .Y(Y), .FAULT_CONST(128'h8C784), .TIMEOUT(TIMEOUT), .LOCK_LIMIT(LOCK_LIMIT), .CW(CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .plain_text       (plain_text),
        .cipher_text      (cipher_text),
        .tag              (tag),
        .encryption_ready (encryption_ready),
        .dec_plain_text   (dec_plain_text),
        .dec_tag          (dec_tag),
        .decryption_ready (decryption_ready),
        .lock_clear       (lock_clear),
        .rel              (rel_if),
        .fault            (fault),
        .fault_count      (fault_count),
        .locked           (locked),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int e, input int d, input logic [Y-1:0] pt,
                                input logic [Y-1:0] ct, input logic [127:0] tg, input logic [127:0] dtg,
                                input bit flip, input bit rel);
        vec_t v;
        v.name = name; v.enc_dly = e; v.dec_dly = d; v.pt = pt; v.ct = ct;
        v.tg = tg; v.dtg = dtg; v.pt_flip = flip; v.exp_rel = rel;
        return v;
    endfunction

    // One transaction: start, raise the ready levels at the given delays, hold
    // out_ready low for the first bp valid cycles, then compare against expectations.
    task automatic run_txn(input vec_t v, input int bp);
        int valid_cycles = 0, valid_at = -1, fault_pulses = 0, fault_at = -1;
        int gate_err = 0, data_err = 0, n, exp_at;
        if (v.enc_dly > TIMEOUT) begin
            n = TIMEOUT + 6;            exp_at = TIMEOUT + 1;
        end else if (v.dec_dly > TIMEOUT) begin
            n = v.enc_dly + TIMEOUT + 6; exp_at = v.enc_dly + TIMEOUT + 1;
        end else begin
            n = v.enc_dly + v.dec_dly + bp + 6; exp_at = v.enc_dly + v.dec_dly + 2;
        end
        @(posedge clk); #1;
        start = 1'b1; plain_text = v.pt; cipher_text = v.ct; tag = v.tg; dec_tag = v.dtg;
        dec_plain_text = v.pt ^ Y'(v.pt_flip);
        encryption_ready = 1'b0; decryption_ready = 1'b0; rel_if.out_ready = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            encryption_ready = (k >= v.enc_dly);
            decryption_ready = (k >= v.enc_dly + v.dec_dly);
            rel_if.out_ready = !(rel_if.out_valid && valid_cycles < bp);
            @(negedge clk);
            if (rel_if.out_valid) begin
                valid_cycles++;
                if (valid_at < 0) valid_at = k;
                if (rel_if.out_tag !== v.tg || rel_if.out_cipher_text !== v.ct) data_err++;
            end else if (rel_if.out_tag !== '0 || rel_if.out_cipher_text !== '0) begin
                gate_err++;
            end
            if (fault) begin
                fault_pulses++;
                if (fault_at < 0) fault_at = k;
            end
        end
        @(posedge clk); #1;
        encryption_ready = 1'b0; decryption_ready = 1'b0; rel_if.out_ready = 1'b1;
        if (v.exp_rel) begin
            check({v.name, "_valid_cycles"}, valid_cycles, bp + 1);
            check({v.name, "_valid_at"}, valid_at, exp_at);
            check({v.name, "_data"}, data_err, 0);
            check({v.name, "_no_fault"}, fault_pulses, 0);
        end else begin
            exp_faults++;
            exp_lock++;
            check({v.name, "_no_valid"}, valid_cycles, 0);
            check({v.name, "_fault_pulses"}, fault_pulses, 1);
            check({v.name, "_fault_at"}, fault_at, exp_at);
        end
        @(negedge clk);
        check({v.name, "_gating"}, gate_err, 0);
        check({v.name, "_fault_count"}, fault_count, exp_faults);
        check({v.name, "_locked"}, locked, exp_lock >= LOCK_LIMIT);
        check({v.name, "_busy"}, busy, 0);
    endtask

    task automatic clear_lock();
        @(posedge clk); #1; lock_clear = 1'b1;
        @(posedge clk); #1; lock_clear = 1'b0;
        exp_lock = 0;
        @(negedge clk);
        check("clear_locked", locked, 0);
        check("clear_busy", busy, 0);
        check("clear_fault_count", fault_count, exp_faults);
    endtask

    localparam logic [127:0] T0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] T1 = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;
    localparam logic [127:0] FC = 128'h8C784;
`ifdef ASCON_PT_CHECK_EN
    localparam bit PT_REL = 1'b0;
`else
    localparam bit PT_REL = 1'b1;
`endif

    initial begin
        vec_t vecs[5];
        int fault_seen;
        vecs[0] = mk("nominal",  10, 20, 40'h11_2233_4455, 40'h12_3456_789A, T0, T0,        1'b0, 1'b1);
        vecs[1] = mk("tag_mism",  5,  7, 40'h01_0000_0002, 40'h00_0000_0001, T0, T0 ^ 128'd1, 1'b0, 1'b0);
        vecs[2] = mk("simult",    4,  0, 40'h77_0000_0077, 40'hFF_FFFF_FFFF, T1, T1,        1'b0, 1'b1);
        vecs[3] = mk("pt_flip",   6,  3, 40'hA5_A500_0001, 40'h33_4455_6677, T1, T1,        1'b1, PT_REL);
        vecs[4] = mk("nominal2",  2,  2, 40'h00_0000_0000, 40'h55_AA55_AA55, ~T0, ~T0,      1'b0, 1'b1);

        rel_if.out_ready = 1'b1;
        #12;
        check("rst_out_valid", rel_if.out_valid, 0);
        check("rst_out_tag", rel_if.out_tag, 0);
        check("rst_out_ct", rel_if.out_cipher_text, 0);
        check("rst_fault", fault, 0);
        check("rst_fault_count", fault_count, 0);
        check("rst_locked", locked, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 5; i++) run_txn(vecs[i], 0);

        // Fault-constant tags until the lockout threshold is reached.
        while (exp_lock < LOCK_LIMIT)
            run_txn(mk("tag_const", 3, 4, 40'h1, 40'h2, FC, FC, 1'b0, 1'b0), 0);

        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; tag = T0; dec_tag = T0;
        encryption_ready = 1'b1; decryption_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1; encryption_ready = 1'b0; decryption_ready = 1'b0;
        @(negedge clk);
        check("locked_start_busy", busy, 0);
        check("locked_start_locked", locked, 1);
        check("locked_start_valid", rel_if.out_valid, 0);
        clear_lock();

        run_txn(mk("ct_const", 3, 3, 40'h9, 40'h00_0008_C784, T0, T0, 1'b0, 1'b0), 0);
        run_txn(mk("enc_timeout", 5000, 0, 40'h9, 40'h1, T0, T0, 1'b0, 1'b0), 0);
        run_txn(mk("dec_timeout", 3, 5000, 40'h9, 40'h1, T0, T0, 1'b0, 1'b0), 0);
        clear_lock();

        run_txn(mk("backpress", 3, 5, 40'h42, 40'h0F_0F0F_0F0F, T1, T1, 1'b0, 1'b1), 50);

        // Asynchronous reset while waiting for decryption.
        @(posedge clk); #1; start = 1'b1; cipher_text = 40'h1; tag = T0; dec_tag = T0;
        @(posedge clk); #1; start = 1'b0; encryption_ready = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_fault_count", fault_count, exp_faults);
        #2; rst = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", rel_if.out_valid, 0);
        check("async_rst_tag", rel_if.out_tag, 0);
        check("async_rst_fault", fault, 0);
        check("async_rst_fault_count", fault_count, 0);
        exp_faults = 0;
        exp_lock = 0;
        encryption_ready = 1'b0;
        @(negedge clk); rst = 1'b1;
        fault_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (fault) fault_seen++;
        end
        check("post_rst_no_fault", fault_seen, 0);
        run_txn(vecs[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
